// File: rtl/multi_tile_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : multi_tile_result_fifo
//  Purpose  : NUM_TILES independent circular result FIFOs merged onto a single
//             registered output stream by a round-robin arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_tile_result_fifo #(
  parameter int NUM_TILES    = 4,
  parameter int DEPTH        = 128,
  parameter int DATA_WIDTH   = 16,
  parameter int AFULL_MARGIN = 8
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset_n,
  input  logic [NUM_TILES*DATA_WIDTH-1:0]          i_wr_data,
  input  logic [NUM_TILES-1:0]                     i_wr_en,
  output logic [NUM_TILES-1:0]                     o_full,
  output logic [NUM_TILES-1:0]                     o_afull,
  output logic [NUM_TILES*($clog2(DEPTH)+1)-1:0]   o_count,
  output logic [NUM_TILES-1:0]                     o_ovf,
  input  logic                                     i_clear_ovf,
  output logic                                     o_m_valid,
  input  logic                                     i_m_ready,
  output logic [DATA_WIDTH-1:0]                    o_m_data,
  output logic [$clog2(NUM_TILES)-1:0]             o_m_tile_id
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(NUM_TILES);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - AFULL_MARGIN);
  localparam logic [TW-1:0] LAST_TILE = TW'(NUM_TILES - 1);

  // Storage is deliberately not reset; pointers alone define validity.
  logic [DATA_WIDTH-1:0] mem_q [NUM_TILES][DEPTH];

  logic [NUM_TILES-1:0][PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [NUM_TILES-1:0][PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NUM_TILES-1:0][CW-1:0] count_q, count_d;
  logic [NUM_TILES-1:0]         ovf_q, ovf_d;
  logic [TW-1:0]                prio_q;      // tile with highest priority this cycle
  logic                         valid_q;
  logic [DATA_WIDTH-1:0]        data_q;
  logic [TW-1:0]                tile_q;

  logic [NUM_TILES-1:0] accept;
  logic [NUM_TILES-1:0] nonempty;
  logic [NUM_TILES-1:0] pop_vec;
  logic                 grant_found;
  logic [TW-1:0]        grant_idx;
  logic                 load;
  logic [DATA_WIDTH-1:0] rd_data;

  // Per-channel write acceptance (a same-cycle pop never frees room) and occupancy flags.
  always_comb begin
    accept   = '0;
    nonempty = '0;
    for (int t = 0; t < NUM_TILES; t++) begin
      accept[t]   = i_wr_en[t] && (count_q[t] != DEPTH_C);
      nonempty[t] = (count_q[t] != '0);
    end
  end

  // Round-robin search upward from prio_q, wrapping, for the first non-empty channel.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      if (!grant_found && nonempty[(int'(prio_q) + i) % NUM_TILES]) begin
        grant_found = 1'b1;
        grant_idx   = TW'((int'(prio_q) + i) % NUM_TILES);
      end
    end
  end

  assign load    = (!valid_q || i_m_ready) && grant_found;
  assign rd_data = mem_q[grant_idx][rd_ptr_q[grant_idx]];

  // Pointer and count next-state; a write and pop together leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_vec  = '0;
    for (int t = 0; t < NUM_TILES; t++) begin
      pop_vec[t] = load && (grant_idx == TW'(t));
      if (accept[t])  wr_ptr_d[t] = wr_ptr_q[t] + 1'b1;
      if (pop_vec[t]) rd_ptr_d[t] = rd_ptr_q[t] + 1'b1;
      case ({accept[t], pop_vec[t]})
        2'b10:   count_d[t] = count_q[t] + 1'b1;
        2'b01:   count_d[t] = count_q[t] - 1'b1;
        default: count_d[t] = count_q[t];
      endcase
    end
  end

  // Sticky overflow: a new drop wins over a coincident clear.
  always_comb begin
    ovf_d = i_clear_ovf ? '0 : ovf_q;
    for (int t = 0; t < NUM_TILES; t++) begin
      if (i_wr_en[t] && (count_q[t] == DEPTH_C)) ovf_d[t] = 1'b1;
    end
  end

  // Channel memories: write accepted words at each channel's write pointer.
  always_ff @(posedge i_clk) begin
    for (int t = 0; t < NUM_TILES; t++) begin
      if (accept[t]) mem_q[t][wr_ptr_q[t]] <= i_wr_data[t*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Channel pointers, counts and overflow flags.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Output register and arbiter pointer; priority moves to the tile after the winner.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tile_q  <= '0;
      prio_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= rd_data;
      tile_q  <= grant_idx;
      prio_q  <= (grant_idx == LAST_TILE) ? '0 : grant_idx + 1'b1;
    end else if (i_m_ready) begin
      valid_q <= 1'b0;
    end
  end

  generate
    for (genvar g = 0; g < NUM_TILES; g++) begin : g_status
      assign o_count[g*CW +: CW] = count_q[g];
      assign o_full[g]           = (count_q[g] == DEPTH_C);
      assign o_afull[g]          = (count_q[g] >= AFULL_LVL);
    end
  endgenerate

  assign o_ovf       = ovf_q;
  assign o_m_valid   = valid_q;
  assign o_m_data    = data_q;
  assign o_m_tile_id = tile_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_tile_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_tile_result_fifo
//  Purpose  : Directed scoreboard bench for multi_tile_result_fifo.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_tile_result_fifo;

  localparam int NT = 4;
  localparam int DP = 128;
  localparam int DW = 16;
  localparam int CW = 8;
  localparam int TW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NT*DW-1:0] wr_data;
  logic [NT-1:0]    wr_en;
  logic [NT-1:0]    full, afull, ovf;
  logic [NT*CW-1:0] count;
  logic             clear_ovf;
  logic             m_valid;
  logic             m_ready;
  logic [DW-1:0]    m_data;
  logic [TW-1:0]    m_tile;

  int checks = 0;
  int errors = 0;
  logic [TW+DW-1:0] exp_q [$];

  multi_tile_result_fifo #(
    .NUM_TILES(NT), .DEPTH(DP), .DATA_WIDTH(DW), .AFULL_MARGIN(8)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_wr_data(wr_data), .i_wr_en(wr_en),
    .o_full(full), .o_afull(afull), .o_count(count), .o_ovf(ovf),
    .i_clear_ovf(clear_ovf), .o_m_valid(m_valid), .i_m_ready(m_ready),
    .o_m_data(m_data), .o_m_tile_id(m_tile)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic logic [CW-1:0] cnt(input int t);
    return count[t*CW +: CW];
  endfunction

  // Monitor: every transferred word is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stray_word: got tile=%0d data=%h required no word", m_tile, m_data);
      end else begin
        logic [TW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({m_tile, m_data} !== e) begin
          errors++;
          $display("FAIL word: got tile=%0d data=%h required tile=%0d data=%h",
                   m_tile, m_data, e[TW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input int t, input logic [DW-1:0] d, input bit expect_it);
    wr_en               = '0;
    wr_en[t]            = 1'b1;
    wr_data[t*DW +: DW] = d;
    if (expect_it) exp_q.push_back({TW'(t), d});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    wr_en = '0; clear_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_en = '0; wr_data = '0; clear_ovf = 1'b0; m_ready = 1'b0;
    #1;
    // Reset state
    chk("rst_valid", m_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_afull", afull, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single tile stream, latency and same-cycle write+pop
    m_ready = 1'b1;
    tick();
    drive_wr(2, 16'h1111, 1);
    tick();
    chk("lat_edgeN_valid", m_valid, 0);
    drive_wr(2, 16'h1112, 1);
    tick();
    chk("lat_first_valid", m_valid, 1);
    chk("lat_first_data", m_data, 16'h1111);
    chk("lat_first_tile", m_tile, 2);
    drive_wr(2, 16'h1113, 1);
    tick();
    drive_wr(2, 16'h1114, 1);
    tick();
    wr_en = '0;
    tick();
    tick();
    chk("single_end_valid", m_valid, 0);
    chk("single_end_count", cnt(2), 0);
    drain("single", 20);

    // Round-robin
    do_reset();
    m_ready = 1'b0;
    tick();
    wr_en = 4'b1111;
    for (int t = 0; t < NT; t++) wr_data[t*DW +: DW] = 16'h0A00 + 16'(t);
    tick();
    for (int t = 0; t < NT; t++) wr_data[t*DW +: DW] = 16'h0B00 + 16'(t);
    for (int t = 0; t < NT; t++) exp_q.push_back({TW'(t), 16'h0A00 + 16'(t)});
    for (int t = 0; t < NT; t++) exp_q.push_back({TW'(t), 16'h0B00 + 16'(t)});
    tick();
    wr_en = '0;
    tick();
    chk("rr_hold_tile", m_tile, 0);
    chk("rr_count0", cnt(0), 1);
    chk("rr_count3", cnt(3), 2);
    m_ready = 1'b1;
    repeat (8) tick();
    chk("rr_8_consumed", exp_q.size(), 0);
    chk("rr_end_valid", m_valid, 0);

    // Backpressure
    do_reset();
    m_ready = 1'b0;
    tick();
    drive_wr(2, 16'h2001, 1); tick();
    drive_wr(2, 16'h2002, 1); tick();
    drive_wr(0, 16'h2003, 1); tick();
    wr_en = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", m_valid, 1);
      chk("bp_data", m_data, 16'h2001);
      chk("bp_tile", m_tile, 2);
    end
    // After tile 2 wins, priority is tile 3 -> wrap to 0 before tile 2 again.
    exp_q.delete();
    exp_q.push_back({2'd2, 16'h2001});
    exp_q.push_back({2'd0, 16'h2003});
    exp_q.push_back({2'd2, 16'h2002});
    m_ready = 1'b1;
    drain("bp", 20);

    // Fill tile 1, almost-full/full, overflow and clear
    do_reset();
    m_ready = 1'b0;
    tick();
    drive_wr(0, 16'h0F00, 1); tick();
    wr_en = '0; tick();
    for (int k = 1; k <= DP; k++) begin
      drive_wr(1, 16'hA000 + 16'(k), 1);
      tick();
      if (k >= 118) begin
        chk("fill_count", cnt(1), k);
        chk("fill_afull", afull[1], (k >= 120));
        chk("fill_full", full[1], (k == DP));
      end
    end
    drive_wr(1, 16'hDEAD, 0); tick();
    wr_en = '0;
    chk("ovf_set", ovf, 4'b0010);
    chk("ovf_count", cnt(1), DP);
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    chk("ovf_cleared", ovf, 0);
    drive_wr(1, 16'hDEAE, 0); clear_ovf = 1'b1; tick();
    wr_en = '0; clear_ovf = 1'b0;
    chk("ovf_clear_vs_set", ovf, 4'b0010);
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    chk("ovf_cleared2", ovf, 0);
    m_ready = 1'b1;
    drain("fill", 300);

    // Tile 3 full with coincident grant and write
    do_reset();
    m_ready = 1'b0;
    tick();
    drive_wr(0, 16'h0C00, 1); tick();
    wr_en = '0; tick();
    for (int k = 1; k <= DP; k++) begin
      drive_wr(3, 16'h3000 + 16'(k), 1);
      tick();
    end
    chk("t3_full", full, 4'b1000);
    drive_wr(3, 16'hBEEF, 0);
    m_ready = 1'b1;
    tick();
    wr_en = '0; m_ready = 1'b0;
    chk("t3_count", cnt(3), DP - 1);
    chk("t3_ovf", ovf, 4'b1000);
    chk("t3_out_data", m_data, 16'h3001);
    chk("t3_out_tile", m_tile, 3);

    // Reset mid-burst discards everything
    drive_wr(0, 16'h5001, 0); tick();
    drive_wr(0, 16'h5002, 0); tick();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_full", full, 0);
    wr_en = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    repeat (6) tick();
    chk("post_rst_valid", m_valid, 0);
    chk("post_rst_count", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
